// File: rtl/sel_pkg.sv
// Shared types and width helpers for the sequential candidate-select controller.
package sel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // A value range or count of 1 still needs one bit to carry it.
  function automatic int val_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic int idx_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/cand_step.sv
// Single-lane candidate generator: cand = (seed + idx) mod SIZE, natural IW-bit wrap.
module cand_step
  import sel_pkg::*;
#(
  parameter int IW = 4,
  parameter int KW = 3
) (
  input  logic [IW-1:0] seed_q,
  input  logic [KW-1:0] idx,
  output logic [IW-1:0] cand
);

  // K <= SIZE guarantees KW <= IW, so the cast only ever zero-extends.
  assign cand = seed_q + IW'(idx);

endmodule

// File: rtl/sel_scan_ctrl.sv
// Sequential search controller: walks K candidates one per clock and returns
// the lowest index whose candidate equals the target.
//
//   state | meaning
//   IDLE  | waiting for a job, in_ready high
//   SCAN  | comparing candidate idx against target_q, one per cycle
//   DONE  | result/found presented with out_valid until consumer takes it
module sel_scan_ctrl
  import sel_pkg::*;
#(
  parameter int K    = 8,
  parameter int SIZE = 16,
  localparam int IW  = val_width(SIZE),
  localparam int KW  = idx_width(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] seed,
  input  logic [IW-1:0] target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [KW-1:0] result,
  output logic          found,
  output logic          busy
);

  localparam logic [KW-1:0] IDX_LAST = KW'(K - 1);

  state_e        state;
  logic [KW-1:0] idx;
  logic [IW-1:0] seed_q;
  logic [IW-1:0] target_q;
  logic [IW-1:0] cand;

  cand_step #(
    .IW(IW),
    .KW(KW)
  ) u_cand_step (
    .seed_q(seed_q),
    .idx   (idx),
    .cand  (cand)
  );

  // Handshake flags are registered alongside the state so they depend on
  // nothing but the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      seed_q    <= '0;
      target_q  <= '0;
      result    <= '0;
      found     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            seed_q   <= seed;
            target_q <= target;
            idx      <= '0;
            state    <= SCAN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          if (cand == target_q) begin
            result    <= idx;
            found     <= 1'b1;
            state     <= DONE;
            out_valid <= 1'b1;
          end else if (idx == IDX_LAST) begin
            result    <= '0;
            found     <= 1'b0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// Directed bench for sel_scan_ctrl (K=8, SIZE=16) with hand-computed expectations.
module tb_sel_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] seed;
  logic [3:0] target;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] result;
  logic       found;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  sel_scan_ctrl #(.K(8), .SIZE(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .seed     (seed),
    .target   (target),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .found    (found),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one job with out_ready low, scramble inputs after accept, measure latency.
  task automatic run_job(input string tag, input logic [3:0] s, input logic [3:0] t,
                         input int exp_res, input int exp_found, input int exp_lat);
    int lat;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    seed      = s;
    target    = t;
    tick();
    in_valid = 1'b0;
    seed     = ~s;
    target   = s;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, int'(result), exp_res);
    chk({tag, "_found"}, int'(found), exp_found);
    chk({tag, "_inrdy"}, int'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, int'(out_valid), 0);
    chk({tag, "_idle"}, int'(in_ready), 1);
  endtask

  initial begin
    int bc;
    int ov_cnt;
    int ov_at[$];
    int c_res;
    int c_fnd;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; seed = '0; target = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_inrdy", int'(in_ready), 1);
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res", int'(result), 0);
    chk("rst_found", int'(found), 0);

    run_job("wrap", 4'd14, 4'd5, 7, 1, 8);
    run_job("miss", 4'd0, 4'd12, 0, 0, 8);
    run_job("mid", 4'd3, 4'd6, 3, 1, 4);

    // Immediate match: busy high for exactly two cycles with out_ready held.
    out_ready = 1'b1; in_valid = 1'b1; seed = 4'd5; target = 4'd5;
    tick();
    in_valid = 1'b0;
    bc = 0; c_res = -1; c_fnd = -1;
    for (int i = 0; i < 6; i++) begin
      if (busy) bc++;
      if (out_valid) begin c_res = int'(result); c_fnd = int'(found); end
      tick();
    end
    chk("imm_busy_cycles", bc, 2);
    chk("imm_res", c_res, 0);
    chk("imm_found", c_fnd, 1);
    out_ready = 1'b0;

    // Stall in DONE with a rejected job offered mid-stall.
    run_job("pre_stall_dummy", 4'd1, 4'd1, 0, 1, 1);
    in_valid = 1'b1; seed = 4'd14; target = 4'd5;
    tick();
    in_valid = 1'b0;
    bc = 0;
    while (!out_valid && bc < 50) begin tick(); bc++; end
    chk("stall_lat", bc, 8);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ov", int'(out_valid), 1);
      chk("stall_res", int'(result), 7);
      chk("stall_found", int'(found), 1);
      chk("stall_inrdy", int'(in_ready), 0);
      if (i == 2) begin in_valid = 1'b1; seed = 4'd5; target = 4'd5; end
      else in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_rel_ov", int'(out_valid), 0);
    chk("stall_rel_inrdy", int'(in_ready), 1);
    bc = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy || out_valid) bc++;
      tick();
    end
    chk("stall_no_queue", bc, 0);

    // Reset mid-SCAN at idx=3.
    in_valid = 1'b1; seed = 4'd0; target = 4'd12;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_inrdy", int'(in_ready), 1);
    chk("midrst_ov", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    ov_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) ov_cnt++;
      tick();
    end
    chk("midrst_no_result", ov_cnt, 0);

    // Back-to-back jobs: one accepted every 10 cycles.
    out_ready = 1'b1; in_valid = 1'b1; seed = 4'd14; target = 4'd5;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (out_valid) begin
        ov_at.push_back(c);
        chk("b2b_res", int'(result), 7);
        chk("b2b_found", int'(found), 1);
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", ov_at.size(), 4);
    for (int j = 0; j < ov_at.size(); j++) chk("b2b_at", ov_at[j], 9 + 10 * j);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
